// File: rtl/div_reconstruct_if.sv
`default_nettype none
// =============================================================================
// Module   : div_reconstruct_if
// Brief    : start/done handshake and operand/result bundle for div_reconstruct
// Revision : 1.0 - initial release
// =============================================================================
interface div_reconstruct_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     remainder;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   dividend;
    logic                 legal;

    modport master (
        output start, quotient, divisor, remainder,
        input  busy, done, dividend, legal
    );

    modport slave (
        input  start, quotient, divisor, remainder,
        output busy, done, dividend, legal
    );
endinterface
`default_nettype wire

// File: rtl/div_reconstruct.sv
`default_nettype none
// =============================================================================
// Module   : div_reconstruct
// Brief    : shift-add rebuild of dividend = quotient*divisor + remainder,
//            with a legality flag for the division triple
// Revision : 1.0 - initial release
// =============================================================================
module div_reconstruct #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    div_reconstruct_if.slave    bus
);
    localparam int                   c_cnt_w    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0]   c_cnt_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_md;
    logic [WIDTH-1:0]     r_mq;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_legal_next;
    logic                 r_busy;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_dividend;
    logic                 r_legal;

    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_legal_in;

    // Max result is 2^(2W) - 2^W, so the 2W-bit sum cannot carry out.
    assign w_acc_next = r_acc + (r_mq[0] ? r_md : '0);
    assign w_legal_in = (bus.divisor != '0) && (bus.remainder < bus.divisor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_md         <= '0;
            r_mq         <= '0;
            r_cnt        <= '0;
            r_legal_next <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_dividend   <= '0;
            r_legal      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_acc        <= {{WIDTH{1'b0}}, bus.remainder};
                        r_md         <= {{WIDTH{1'b0}}, bus.divisor};
                        r_mq         <= bus.quotient;
                        r_cnt        <= '0;
                        r_legal_next <= w_legal_in;
                        r_busy       <= 1'b1;
                        r_state      <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_mq  <= r_mq >> 1;
                    r_md  <= r_md << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_dividend <= w_acc_next;
                        r_legal    <= r_legal_next;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.dividend = r_dividend;
    assign bus.legal    = r_legal;
endmodule
`default_nettype wire

// File: doc/div_reconstruct.md
# div_reconstruct

Sequential shift-add multiply-accumulate unit that runs division in the reverse direction: from a quotient, divisor and remainder it rebuilds the dividend as quotient × divisor + remainder. It also flags whether the triple is a legal division result. It sits beside the division/modulus demo logic as its inverse and checker, and takes one start/done handshake per operation.

## Interface
- WIDTH, 8, operand width in bits; must be ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- quotient  input  WIDTH  unsigned quotient, captured on accepted start.
- divisor  input  WIDTH  unsigned divisor, captured on accepted start.
- remainder  input  WIDTH  unsigned remainder, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is valid.
- dividend  output  2*WIDTH  reconstructed quotient×divisor+remainder; held until the next done.
- legal  output  1  registered with dividend: 1 iff divisor≠0 and remainder<divisor.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture operands.
  - acc ← zero-extended remainder.
  - mq ← quotient.
  - md ← zero-extended divisor (2*WIDTH bits).
  - cnt ← 0.
  - Capture legal_next from the raw inputs.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, one iteration per cycle:
  - If mq[0]=1, acc ← acc + md.
  - mq ← mq>>1; md ← md<<1; cnt ← cnt+1.
- RUN exit: on the iteration with cnt=WIDTH-1, load dividend with the final acc value, load legal from legal_next, and go to DONE.
- DONE: done=1 for exactly this one cycle.
  - start=1: accept new operands as in IDLE and go to RUN.
  - start=0: go to IDLE.
- start during RUN is ignored; there is no queuing and no error indication.
- Width rule: the maximum result is (2^W−1)² + (2^W−1) = 2^(2W) − 2^W, so the 2W-bit accumulator never overflows. No carry-out is needed.
- Arithmetic is unsigned only.
- divisor=0: the product term is 0, so dividend = remainder and legal=0.
- remainder ≥ divisor: dividend is still computed exactly; legal=0.
- dividend and legal change only on the cycle that enters DONE. They are stable otherwise, including during RUN.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, dividend=0, legal=0, all internal registers 0. Effect is immediate, without waiting for a clock edge.
- Reset release is synchronous in effect: the first start is sampled on the first rising edge with rst_n high.
- Reset asserted during RUN aborts the operation. No done is produced, and dividend returns to 0.
- Latency, measured from the accepting edge E:
  - busy=1 from E through E+WIDTH.
  - done=1 and the new dividend are valid from E+WIDTH to E+WIDTH+1.
- The operation is fixed-length: WIDTH cycles regardless of operand values. There is no early exit.
- Throughput: with start held high, a new operation begins every WIDTH+1 cycles. busy drops for exactly the DONE cycle.
- Input operands need to be stable only at the accepting edge. Later changes to the inputs have no effect.

## Test plan
- Basic (WIDTH=8): quotient=13, divisor=7, remainder=5, start for 1 cycle.
  - Required: busy high for 8 cycles, then a single done pulse, dividend=96, legal=1.
- Maximum values: quotient=255, divisor=255, remainder=254.
  - Required: dividend=65279, legal=1, no overflow.
- Divide-by-zero triple: quotient=9, divisor=0, remainder=3.
  - Required: dividend=3, legal=0.
- Illegal remainder: quotient=4, divisor=5, remainder=5.
  - Required: dividend=25, legal=0.
- Handshake checks:
  - Pulse start with new operands mid-RUN: ignored, and the first result is unchanged.
  - Hold start high with new operands (q=2, d=3, r=1): the second operation starts in the DONE cycle, giving dividend=7 after WIDTH+1 more cycles and exactly one done per operation.
- Reset mid-operation: drop rst_n 3 cycles after start.
  - Required: busy=0, done=0, dividend=0 immediately, and no done pulse afterwards.
  - After release, a fresh operation (q=1, d=1, r=0) gives dividend=1.
